// File: rtl/wb_stage.sv
// wb_stage: writeback stage with M->W register, result select, HI/LO registers and commit counters
module wb_stage #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall_w,
    input  logic                   flush_w,
    input  logic                   valid_m,
    input  logic                   reg_write_m,
    input  logic                   mem_to_reg_m,
    input  logic [31:0]            read_value_m,
    input  logic [31:0]            alu_out_m,
    input  logic [4:0]             write_reg_m,
    input  logic                   has_div_m,
    input  logic [31:0]            div_hi_m,
    input  logic [31:0]            div_lo_m,
    output logic                   reg_write_w,
    output logic [4:0]             write_reg_w,
    output logic [31:0]            result_w,
    output logic [31:0]            hi_w,
    output logic [31:0]            lo_w,
    output logic [31:0]            hi_fwd,
    output logic [31:0]            lo_fwd,
    output logic [COUNT_WIDTH-1:0] retired_count,
    output logic [COUNT_WIDTH-1:0] div_count
);
    logic                   valid_q, valid_d;
    logic                   reg_write_q, reg_write_d;
    logic                   mem_to_reg_q, mem_to_reg_d;
    logic [31:0]            read_value_q, read_value_d;
    logic [31:0]            alu_out_q, alu_out_d;
    logic [4:0]             write_reg_q, write_reg_d;
    logic                   has_div_q, has_div_d;
    logic [31:0]            div_hi_q, div_hi_d;
    logic [31:0]            div_lo_q, div_lo_d;
    logic [31:0]            hi_q, hi_d;
    logic [31:0]            lo_q, lo_d;
    logic [COUNT_WIDTH-1:0] retired_q, retired_d;
    logic [COUNT_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic                   commit;
    logic                   load;
    logic                   div_commit;

    // the W instruction leaves on any unstalled edge; flush only kills the incoming one
    assign commit     = valid_q && !stall_w;
    assign div_commit = commit && has_div_q;
    assign load       = !stall_w && !flush_w;

    // next state: hold on stall, bubble on flush, otherwise take M contents
    always_comb begin
        valid_d      = stall_w ? valid_q      : (load ? valid_m      : 1'b0);
        reg_write_d  = stall_w ? reg_write_q  : (load ? reg_write_m  : 1'b0);
        mem_to_reg_d = stall_w ? mem_to_reg_q : (load ? mem_to_reg_m : 1'b0);
        read_value_d = stall_w ? read_value_q : (load ? read_value_m : 32'd0);
        alu_out_d    = stall_w ? alu_out_q    : (load ? alu_out_m    : 32'd0);
        write_reg_d  = stall_w ? write_reg_q  : (load ? write_reg_m  : 5'd0);
        has_div_d    = stall_w ? has_div_q    : (load ? has_div_m    : 1'b0);
        div_hi_d     = stall_w ? div_hi_q     : (load ? div_hi_m     : 32'd0);
        div_lo_d     = stall_w ? div_lo_q     : (load ? div_lo_m     : 32'd0);
        hi_d         = div_commit ? div_hi_q : hi_q;
        lo_d         = div_commit ? div_lo_q : lo_q;
        retired_d    = commit ? retired_q + 1'b1 : retired_q;
        div_cnt_d    = div_commit ? div_cnt_q + 1'b1 : div_cnt_q;
    end

    // state registers; reset discards any pending HI/LO update
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            read_value_q <= 32'd0;
            alu_out_q    <= 32'd0;
            write_reg_q  <= 5'd0;
            has_div_q    <= 1'b0;
            div_hi_q     <= 32'd0;
            div_lo_q     <= 32'd0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            retired_q    <= '0;
            div_cnt_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            read_value_q <= read_value_d;
            alu_out_q    <= alu_out_d;
            write_reg_q  <= write_reg_d;
            has_div_q    <= has_div_d;
            div_hi_q     <= div_hi_d;
            div_lo_q     <= div_lo_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            retired_q    <= retired_d;
            div_cnt_q    <= div_cnt_d;
        end
    end

    // register-file write port and forwarding of an in-flight divide
    always_comb begin
        result_w      = mem_to_reg_q ? read_value_q : alu_out_q;
        write_reg_w   = write_reg_q;
        reg_write_w   = valid_q && reg_write_q && (write_reg_q != 5'd0);
        hi_fwd        = (valid_q && has_div_q) ? div_hi_q : hi_q;
        lo_fwd        = (valid_q && has_div_q) ? div_lo_q : lo_q;
        hi_w          = hi_q;
        lo_w          = lo_q;
        retired_count = retired_q;
        div_count     = div_cnt_q;
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage
module tb_wb_stage;
    logic        clock = 1'b0;
    logic        reset, stall_w, flush_w, valid_m, reg_write_m, mem_to_reg_m, has_div_m;
    logic [31:0] read_value_m, alu_out_m, div_hi_m, div_lo_m;
    logic [4:0]  write_reg_m;
    logic        reg_write_w, reg_write_w4;
    logic [4:0]  write_reg_w, write_reg_w4;
    logic [31:0] result_w, hi_w, lo_w, hi_fwd, lo_fwd;
    logic [31:0] result_w4, hi_w4, lo_w4, hi_fwd4, lo_fwd4;
    logic [31:0] retired_count, div_count;
    logic [3:0]  retired_count4, div_count4;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    wb_stage dut (
        .clock(clock), .reset(reset), .stall_w(stall_w), .flush_w(flush_w),
        .valid_m(valid_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
        .read_value_m(read_value_m), .alu_out_m(alu_out_m), .write_reg_m(write_reg_m),
        .has_div_m(has_div_m), .div_hi_m(div_hi_m), .div_lo_m(div_lo_m),
        .reg_write_w(reg_write_w), .write_reg_w(write_reg_w), .result_w(result_w),
        .hi_w(hi_w), .lo_w(lo_w), .hi_fwd(hi_fwd), .lo_fwd(lo_fwd),
        .retired_count(retired_count), .div_count(div_count)
    );

    wb_stage #(.COUNT_WIDTH(4)) dut4 (
        .clock(clock), .reset(reset), .stall_w(stall_w), .flush_w(flush_w),
        .valid_m(valid_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
        .read_value_m(read_value_m), .alu_out_m(alu_out_m), .write_reg_m(write_reg_m),
        .has_div_m(has_div_m), .div_hi_m(div_hi_m), .div_lo_m(div_lo_m),
        .reg_write_w(reg_write_w4), .write_reg_w(write_reg_w4), .result_w(result_w4),
        .hi_w(hi_w4), .lo_w(lo_w4), .hi_fwd(hi_fwd4), .lo_fwd(lo_fwd4),
        .retired_count(retired_count4), .div_count(div_count4)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input logic v, input logic rw, input logic m2r, input logic [31:0] rv,
                         input logic [31:0] alu, input logic [4:0] wr, input logic hd,
                         input logic [31:0] dh, input logic [31:0] dl);
        valid_m = v; reg_write_m = rw; mem_to_reg_m = m2r; read_value_m = rv;
        alu_out_m = alu; write_reg_m = wr; has_div_m = hd; div_hi_m = dh; div_lo_m = dl;
    endtask

    initial begin
        reset = 1'b1; stall_w = 1'b0; flush_w = 1'b0;
        set_m(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_reg_write", {31'd0, reg_write_w}, 0);
        check("rst_write_reg", {27'd0, write_reg_w}, 0);
        check("rst_result", result_w, 0);
        check("rst_hi", hi_w, 0);
        check("rst_lo", lo_w, 0);
        check("rst_hi_fwd", hi_fwd, 0);
        check("rst_lo_fwd", lo_fwd, 0);
        check("rst_retired", retired_count, 0);
        check("rst_div_count", div_count, 0);

        set_m(1, 1, 0, 32'hDEAD, 32'h1234, 5'd8, 0, 0, 0);
        step();
        check("alu_reg_write", {31'd0, reg_write_w}, 1);
        check("alu_write_reg", {27'd0, write_reg_w}, 8);
        check("alu_result", result_w, 32'h1234);
        check("alu_retired_pre", retired_count, 0);

        set_m(1, 1, 1, 32'hFFFFFF80, 32'h55, 5'd0, 0, 0, 0);
        step();
        check("alu_retired_post", retired_count, 1);
        check("ld0_result", result_w, 32'hFFFFFF80);
        check("ld0_reg_write", {31'd0, reg_write_w}, 0);

        set_m(1, 0, 0, 0, 0, 5'd0, 1, 32'd3, 32'd7);
        step();
        check("ld0_retired", retired_count, 2);
        check("div_hi_fwd", hi_fwd, 3);
        check("div_lo_fwd", lo_fwd, 7);
        check("div_hi_w_pre", hi_w, 0);
        check("div_lo_w_pre", lo_w, 0);

        stall_w = 1'b1;
        set_m(1, 1, 0, 0, 32'h99, 5'd4, 1, 32'h11, 32'h22);
        for (int i = 0; i < 3; i++) begin
            flush_w = (i == 1);
            step();
            check("stall_hi_w", hi_w, 0);
            check("stall_div_count", div_count, 0);
            check("stall_retired", retired_count, 2);
            check("stall_hi_fwd", hi_fwd, 3);
        end
        stall_w = 1'b0; flush_w = 1'b0;
        set_m(1, 1, 0, 0, 32'hAAAA, 5'd9, 0, 0, 0);
        step();
        check("div_hi_w", hi_w, 3);
        check("div_lo_w", lo_w, 7);
        check("div_count_1", div_count, 1);
        check("div_retired", retired_count, 3);
        check("post_div_hi_fwd", hi_fwd, 3);
        check("post_div_result", result_w, 32'hAAAA);

        flush_w = 1'b1;
        set_m(1, 1, 0, 0, 32'hBBBB, 5'd10, 0, 0, 0);
        step();
        flush_w = 1'b0;
        set_m(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("flush_retired", retired_count, 4);
        check("flush_reg_write", {31'd0, reg_write_w}, 0);
        check("flush_result", result_w, 0);
        check("flush_div_count", div_count, 1);
        check("flush_lo_fwd", lo_fwd, 7);
        step();
        check("bubble_retired", retired_count, 4);

        set_m(1, 0, 0, 0, 0, 0, 1, 32'd5, 32'd6);
        step();
        check("rdiv_hi_fwd", hi_fwd, 5);
        stall_w = 1'b1; reset = 1'b1;
        step();
        stall_w = 1'b0; reset = 1'b0;
        set_m(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rdiv_hi_w", hi_w, 0);
        check("rdiv_hi_fwd0", hi_fwd, 0);
        check("rdiv_retired", retired_count, 0);
        check("rdiv_div_count", div_count, 0);

        for (int i = 1; i <= 17; i++) begin
            set_m(1, 1, 0, 0, i, 5'd1, 0, 0, 0);
            step();
            check("wrap_result", result_w, i);
        end
        set_m(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("wrap_retired32", retired_count, 17);
        check("wrap_retired4", {28'd0, retired_count4}, 1);
        check("wrap_div_count4", {28'd0, div_count4}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
